// File: rtl/fan_pkg.sv
// Shared definitions for the segmented-reduction pipeline.
//   DEF_DW_DATA / DEF_DW_ROW : default lane product and row-id widths
//   MAX_LANES                : widest supported lane count
//   acc_width()              : output width that cannot overflow for a lane count
//   popcount()               : number of set bits in a lane mask (up to MAX_LANES)
package fan_pkg;

  localparam int DEF_DW_DATA = 8;
  localparam int DEF_DW_ROW  = 4;
  localparam int MAX_LANES   = 128;

  // A sum of NUM_IN signed DW_DATA values needs clog2(NUM_IN) extra bits.
  function automatic int acc_width(input int dw_data, input int num_in);
    return dw_data + $clog2(num_in);
  endfunction

  function automatic logic [31:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_LANES; i++) cnt = cnt + 32'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/fan_seg_reduce_pipe_if.sv
// Beat-level bus of the segmented-reduction pipeline.
//   in_valid/in_ready   : input handshake
//   in_data/in_row      : per-lane signed products and row ids
//   in_lane_vld         : lane carries a real product
//   out_valid/out_ready : output handshake
//   out_data/out_row    : per-lane scan results and passed-through row ids
//   out_lane_vld        : lane holds a finished row sum
// Modports: master = producer/consumer side, slave = the pipeline.
interface fan_seg_reduce_pipe_if
  import fan_pkg::*;
#(
  parameter int NUM_IN  = 32,
  parameter int DW_DATA = DEF_DW_DATA,
  parameter int DW_ROW  = DEF_DW_ROW,
  parameter int DW_ACC  = acc_width(DW_DATA, NUM_IN)
);

  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*DW_DATA-1:0] in_data;
  logic [NUM_IN*DW_ROW-1:0]  in_row;
  logic [NUM_IN-1:0]         in_lane_vld;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_IN*DW_ACC-1:0]  out_data;
  logic [NUM_IN*DW_ROW-1:0]  out_row;
  logic [NUM_IN-1:0]         out_lane_vld;

  modport master (
    output in_valid, in_data, in_row, in_lane_vld, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_lane_vld
  );

  modport slave (
    input  in_valid, in_data, in_row, in_lane_vld, out_ready,
    output in_ready, out_valid, out_data, out_row, out_lane_vld
  );

endinterface

// File: rtl/fan_scan_stage.sv
// One level of the segmented scan: lanes i >= DIST whose window has not yet
// reached a segment start absorb lane i-DIST, then the result is registered.
//   clk, rst_n        : clock, synchronous active-low reset
//   en                : pipeline advance; register holds when low
//   in_valid/out_valid: beat valid travelling alongside the lanes
//   in_acc/out_acc    : per-lane partial sums (DW_ACC each)
//   in_row/out_row    : per-lane row ids (passed through)
//   in_any/out_any    : window contains at least one valid lane
//   in_seg/out_seg    : window already reaches its segment start
module fan_scan_stage
  import fan_pkg::*;
#(
  parameter int NUM_IN = 32,
  parameter int DIST   = 1,
  parameter int DW_ACC = 13,
  parameter int DW_ROW = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [NUM_IN*DW_ACC-1:0] in_acc,
  input  logic [NUM_IN*DW_ROW-1:0] in_row,
  input  logic [NUM_IN-1:0]        in_any,
  input  logic [NUM_IN-1:0]        in_seg,
  output logic                     out_valid,
  output logic [NUM_IN*DW_ACC-1:0] out_acc,
  output logic [NUM_IN*DW_ROW-1:0] out_row,
  output logic [NUM_IN-1:0]        out_any,
  output logic [NUM_IN-1:0]        out_seg
);

  typedef struct packed {
    logic signed [DW_ACC-1:0] acc;
    logic [DW_ROW-1:0]        row;
    logic                     any;
    logic                     seg_flag;
  } lane_t;

  lane_t cur [NUM_IN];
  lane_t nxt [NUM_IN];
  lane_t q   [NUM_IN];

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      cur[i] = '{acc:      in_acc[i*DW_ACC +: DW_ACC],
                 row:      in_row[i*DW_ROW +: DW_ROW],
                 any:      in_any[i],
                 seg_flag: in_seg[i]};
      nxt[i] = cur[i];
    end
    // A clear seg_flag means lanes i-DIST+1..i share one row, so lane i-DIST
    // is in the same segment and its window can be appended.
    for (int i = DIST; i < NUM_IN; i++) begin
      if (!cur[i].seg_flag) begin
        nxt[i].acc      = cur[i].acc + cur[i-DIST].acc;
        nxt[i].any      = cur[i].any | cur[i-DIST].any;
        nxt[i].seg_flag = cur[i-DIST].seg_flag;
      end
    end
  end

  // NOTE: the data registers are reset too, so the pipeline output reads zero
  // straight after reset instead of stale partial sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) q[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      out_valid <= in_valid;
      q         <= nxt;
    end
  end

  always_comb begin
    out_acc = '0;
    out_row = '0;
    out_any = '0;
    out_seg = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      out_acc[i*DW_ACC +: DW_ACC] = q[i].acc;
      out_row[i*DW_ROW +: DW_ROW] = q[i].row;
      out_any[i]                  = q[i].any;
      out_seg[i]                  = q[i].seg_flag;
    end
  end

endmodule

// File: rtl/fan_seg_reduce_pipe.sv
// Segmented row reduction across NUM_IN lanes using a log-depth registered
// scan (N_LEVELS stages, latency N_LEVELS). All stages advance together when
// the output is empty or being taken; otherwise the whole pipe holds.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fan_seg_reduce_pipe_if.slave (input beat, output beat)
// Optional FAN_PERF_CNT_EN adds 32-bit wrapping counters:
//   perf_beats : accepted input beats
//   perf_stall : cycles with out_valid held against !out_ready
//   perf_segs  : finished segments delivered (popcount of out_lane_vld)
module fan_seg_reduce_pipe
  import fan_pkg::*;
#(
  parameter int NUM_IN   = 32,
  parameter int N_LEVELS = $clog2(NUM_IN),
  parameter int DW_DATA  = DEF_DW_DATA,
  parameter int DW_ROW   = DEF_DW_ROW,
  parameter int DW_ACC   = acc_width(DW_DATA, NUM_IN)
) (
  input  logic                clk,
  input  logic                rst_n,
  fan_seg_reduce_pipe_if.slave bus
`ifdef FAN_PERF_CNT_EN
  ,
  output logic [31:0]         perf_beats,
  output logic [31:0]         perf_stall,
  output logic [31:0]         perf_segs
`endif
);

  localparam int AW = NUM_IN * DW_ACC;
  localparam int RW = NUM_IN * DW_ROW;

  logic [AW-1:0]       acc0;
  logic [NUM_IN-1:0]   seg0;
  logic [AW-1:0]       acc_q [N_LEVELS];
  logic [RW-1:0]       row_q [N_LEVELS];
  logic [NUM_IN-1:0]   any_q [N_LEVELS];
  logic [NUM_IN-1:0]   seg_q [N_LEVELS];
  logic [N_LEVELS-1:0] vld_q;
  logic                adv;

  assign adv          = !vld_q[N_LEVELS-1] || bus.out_ready;
  assign bus.in_ready = adv;

  // Invalid lanes enter as zero; a segment starts at lane 0 and at every row change.
  always_comb begin
    acc0    = '0;
    seg0    = '0;
    seg0[0] = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.in_lane_vld[i])
        acc0[i*DW_ACC +: DW_ACC] = DW_ACC'($signed(bus.in_data[i*DW_DATA +: DW_DATA]));
    end
    for (int i = 1; i < NUM_IN; i++)
      seg0[i] = bus.in_row[i*DW_ROW +: DW_ROW] != bus.in_row[(i-1)*DW_ROW +: DW_ROW];
  end

  for (genvar k = 0; k < N_LEVELS; k++) begin : g_stage
    logic [AW-1:0]     a_in;
    logic [RW-1:0]     r_in;
    logic [NUM_IN-1:0] n_in;
    logic [NUM_IN-1:0] s_in;
    logic              v_in;

    if (k == 0) begin : g_first
      assign a_in = acc0;
      assign r_in = bus.in_row;
      assign n_in = bus.in_lane_vld;
      assign s_in = seg0;
      assign v_in = bus.in_valid;
    end else begin : g_next
      assign a_in = acc_q[k-1];
      assign r_in = row_q[k-1];
      assign n_in = any_q[k-1];
      assign s_in = seg_q[k-1];
      assign v_in = vld_q[k-1];
    end

    fan_scan_stage #(
      .NUM_IN (NUM_IN),
      .DIST   (1 << k),
      .DW_ACC (DW_ACC),
      .DW_ROW (DW_ROW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (v_in),
      .in_acc    (a_in),
      .in_row    (r_in),
      .in_any    (n_in),
      .in_seg    (s_in),
      .out_valid (vld_q[k]),
      .out_acc   (acc_q[k]),
      .out_row   (row_q[k]),
      .out_any   (any_q[k]),
      .out_seg   (seg_q[k])
    );
  end

  assign bus.out_valid = vld_q[N_LEVELS-1];
  assign bus.out_data  = acc_q[N_LEVELS-1];
  assign bus.out_row   = row_q[N_LEVELS-1];

  // A lane finishes a row when it ends its run and the run had a real product.
  always_comb begin
    bus.out_lane_vld = '0;
    for (int i = 0; i < NUM_IN - 1; i++)
      bus.out_lane_vld[i] = any_q[N_LEVELS-1][i] &&
        (row_q[N_LEVELS-1][i*DW_ROW +: DW_ROW] != row_q[N_LEVELS-1][(i+1)*DW_ROW +: DW_ROW]);
    bus.out_lane_vld[NUM_IN-1] = any_q[N_LEVELS-1][NUM_IN-1];
  end

`ifdef FAN_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_beats <= '0;
      perf_stall <= '0;
      perf_segs  <= '0;
    end else begin
      if (bus.in_valid && adv)
        perf_beats <= perf_beats + 32'd1;
      if (bus.out_valid && !bus.out_ready)
        perf_stall <= perf_stall + 32'd1;
      if (bus.out_valid && bus.out_ready)
        perf_segs <= perf_segs + popcount(MAX_LANES'(bus.out_lane_vld));
    end
  end
`endif

endmodule

// File: tb/tb_fan_seg_reduce_pipe.sv
// Self-checking bench for fan_seg_reduce_pipe with NUM_IN=8, DW_DATA=8.
// A run-by-run reference model computes the expected row sums of every
// accepted beat; a queue of expectations checks ordering and stall stability.
module tb_fan_seg_reduce_pipe;
  import fan_pkg::*;

  localparam int NUM_IN  = 8;
  localparam int DW_DATA = 8;
  localparam int DW_ROW  = 4;
  localparam int DW_ACC  = 11;
  localparam int LAT     = 3;

  typedef struct packed {
    logic [NUM_IN*DW_ROW-1:0]  row;
    logic [NUM_IN*DW_DATA-1:0] data;
    logic [NUM_IN-1:0]         vld;
  } beat_t;

  typedef struct packed {
    logic [NUM_IN-1:0]        mask;
    logic [NUM_IN-1:0]        care;
    logic [NUM_IN*DW_ACC-1:0] data;
    logic [NUM_IN*DW_ROW-1:0] row;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fan_seg_reduce_pipe_if #(
    .NUM_IN(NUM_IN), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .DW_ACC(DW_ACC)
  ) bus ();

`ifdef FAN_PERF_CNT_EN
  logic [31:0] perf_beats, perf_stall, perf_segs;
`endif

  fan_seg_reduce_pipe #(
    .NUM_IN(NUM_IN), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FAN_PERF_CNT_EN
    ,
    .perf_beats (perf_beats),
    .perf_stall (perf_stall),
    .perf_segs  (perf_segs)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  int   tb_beats = 0;
  int   tb_stall = 0;
  int   tb_segs = 0;
  exp_t expq[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the maximal equal-row runs and sum their valid lanes.
  function automatic exp_t model(input beat_t b);
    exp_t e;
    int   start;
    int   sum;
    bit   any;
    bit   is_end;
    e     = '0;
    e.row = b.row;
    start = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (i == NUM_IN - 1) is_end = 1'b1;
      else is_end = b.row[i*DW_ROW +: DW_ROW] != b.row[(i+1)*DW_ROW +: DW_ROW];
      if (is_end) begin
        sum = 0;
        any = 1'b0;
        for (int j = start; j <= i; j++) begin
          if (b.vld[j]) begin
            sum = sum + int'($signed(b.data[j*DW_DATA +: DW_DATA]));
            any = 1'b1;
          end
        end
        e.mask[i] = any;
        e.care[i] = 1'b1;
        e.data[i*DW_ACC +: DW_ACC] = sum[DW_ACC-1:0];
        start = i + 1;
      end
    end
    return e;
  endfunction

  function automatic logic [NUM_IN*DW_ACC-1:0] care_bits(input logic [NUM_IN-1:0] care);
    logic [NUM_IN*DW_ACC-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_IN; i++) if (care[i]) m[i*DW_ACC +: DW_ACC] = '1;
    return m;
  endfunction

  function automatic int lane_sum(input int i);
    return int'($signed(bus.out_data[i*DW_ACC +: DW_ACC]));
  endfunction

  function automatic beat_t mk(input int r[NUM_IN], input int d[NUM_IN], input logic [NUM_IN-1:0] v);
    beat_t b;
    for (int i = 0; i < NUM_IN; i++) begin
      b.row[i*DW_ROW +: DW_ROW]    = DW_ROW'(r[i]);
      b.data[i*DW_DATA +: DW_DATA] = DW_DATA'(d[i]);
    end
    b.vld = v;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    for (int i = 0; i < NUM_IN; i++) begin
      b.row[i*DW_ROW +: DW_ROW]    = DW_ROW'($urandom_range(0, 3));
      b.data[i*DW_DATA +: DW_DATA] = DW_DATA'($urandom);
    end
    b.vld = NUM_IN'($urandom);
    return b;
  endfunction

  // One clock: drive, check the visible output against the queue head, update the model.
  task automatic step(input bit iv, input beat_t b, input bit ordy, output bit acc);
    exp_t f;
    bus.in_valid    = iv;
    bus.in_row      = b.row;
    bus.in_data     = b.data;
    bus.in_lane_vld = b.vld;
    bus.out_ready   = ordy;
    #1;
    check("in_ready", bus.in_ready, !bus.out_valid || ordy);
    if (bus.out_valid && !ordy) tb_stall++;
    if (bus.out_valid) begin
      if (expq.size() == 0) begin
        check("spurious_out_valid", bus.out_valid, 1'b0);
      end else begin
        f = expq[0];
        check("out_lane_vld", bus.out_lane_vld, f.mask);
        check("out_data", bus.out_data & care_bits(f.care), f.data);
        check("out_row", bus.out_row, f.row);
        if (ordy) begin
          void'(expq.pop_front());
          tb_segs += $countones(f.mask);
        end
      end
    end
    acc = iv && bus.in_ready;
    if (acc) begin
      expq.push_back(model(b));
      tb_beats++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_and_wait(input beat_t b);
    bit a;
    int lat;
    step(1'b1, b, 1'b1, a);
    check("accept", a, 1'b1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step(1'b0, '0, 1'b1, a);
      lat++;
    end
    check("latency", lat, LAT);
  endtask

  task automatic retire_one();
    bit a;
    step(1'b0, '0, 1'b1, a);
  endtask

  task automatic stream(input int n, input int mode, input string tag);
    beat_t beats[$];
    bit    a;
    bit    iv;
    bit    ordy;
    int    idx;
    int    cyc;
    for (int i = 0; i < n; i++) beats.push_back(rnd_beat());
    idx = 0;
    cyc = 0;
    while ((idx < n || expq.size() > 0) && cyc < 2000) begin
      case (mode)
        0:       begin iv = 1'b1;                      ordy = (cyc % 2) == 0; end
        1:       begin iv = $urandom_range(0, 3) != 0; ordy = $urandom_range(0, 2) != 0; end
        default: begin iv = 1'b1;                      ordy = 1'b1; end
      endcase
      iv = iv && (idx < n);
      step(iv, (idx < n) ? beats[idx] : '0, ordy, a);
      if (mode == 2 && iv) check({tag, "_full_rate"}, a, 1'b1);
      if (a) idx++;
      cyc++;
    end
    check({tag, "_sent"}, idx, n);
    check({tag, "_drained"}, expq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    rr[NUM_IN];
    int    dd[NUM_IN];
    beat_t b;
    bit    a;

    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_row      = '0;
    bus.in_lane_vld = '0;
    bus.out_ready   = 1'b0;
    rst_n           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_row", bus.out_row, '0);
    check("rst_out_lane_vld", bus.out_lane_vld, '0);
`ifdef FAN_PERF_CNT_EN
    check("rst_perf_beats", perf_beats, 0);
`endif

    // Single segment, data 1..8.
    rr = '{3, 3, 3, 3, 3, 3, 3, 3};
    dd = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_and_wait(mk(rr, dd, 8'hFF));
    check("single_mask", bus.out_lane_vld, 8'h80);
    check("single_sum", lane_sum(7), 36);
    retire_one();

    // Mixed runs: lanes 1,4,5,7 end runs.
    rr = '{0, 0, 1, 1, 1, 2, 5, 5};
    dd = '{-1, -1, -1, -1, -1, -1, -1, -1};
    send_and_wait(mk(rr, dd, 8'hFF));
    check("mixed_mask", bus.out_lane_vld, 8'hB2);
    check("mixed_sum1", lane_sum(1), -2);
    check("mixed_sum4", lane_sum(4), -3);
    check("mixed_sum5", lane_sum(5), -1);
    check("mixed_sum7", lane_sum(7), -2);
    retire_one();

    // Invalid lanes; upper run has no valid lane.
    rr = '{4, 4, 4, 4, 7, 7, 7, 7};
    dd = '{10, -20, 30, 5, 50, 50, 50, 50};
    send_and_wait(mk(rr, dd, 8'h0F));
    check("inval_mask", bus.out_lane_vld, 8'h08);
    check("inval_sum3", lane_sum(3), 25);
    check("inval_sum7", lane_sum(7), 0);
    retire_one();

    // Most negative products across a single run.
    rr = '{9, 9, 9, 9, 9, 9, 9, 9};
    dd = '{-128, -128, -128, -128, -128, -128, -128, -128};
    send_and_wait(mk(rr, dd, 8'hFF));
    check("extreme_mask", bus.out_lane_vld, 8'h80);
    check("extreme_sum", lane_sum(7), -1024);
    retire_one();

    stream(10, 0, "bp");
    stream(40, 1, "rand");
    stream(12, 2, "thru");

`ifdef FAN_PERF_CNT_EN
    check("perf_beats", perf_beats, tb_beats);
    check("perf_stall", perf_stall, tb_stall);
    check("perf_segs", perf_segs, tb_segs);
`endif

    // Three beats in flight, output stalled, then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      b = rnd_beat();
      step(1'b1, b, 1'b0, a);
      check("flight_accept", a, 1'b1);
    end
    check("flight_out_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0, a);
    rst_n = 1'b1;
    expq.delete();
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_out_lane_vld", bus.out_lane_vld, '0);
    check("mid_rst_out_data", bus.out_data, '0);
`ifdef FAN_PERF_CNT_EN
    check("mid_rst_perf_beats", perf_beats, 0);
    check("mid_rst_perf_stall", perf_stall, 0);
    check("mid_rst_perf_segs", perf_segs, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, a);
      check("no_stale_beat", bus.out_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
